// File: rtl/vram_cpu_port.sv
// Z80 initiator for the tile RAM port: stalls the CPU with WAIT until the CPU blanking
// window opens, then issues one registered strobe. Optional feature: VRAM_POSTED_WRITE_EN.
module vram_cpu_port #(
  parameter logic [15:0] BASE_ADDR = 16'h7400,
  parameter int          ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              z_mreq_n,
  input  logic              z_rd_n,
  input  logic              z_wr_n,
  input  logic [15:0]       z_addr,
  input  logic [7:0]        z_dout,
  output logic [7:0]        z_din,
  output logic              z_wait_n,
  input  logic              cmpblk,
  input  logic              vram_busy,
  output logic              rdn,
  output logic              wrn,
  output logic              tile_ena,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  input  logic [7:0]        dout
);

  typedef enum logic [2:0] {IDLE, WAITWIN, ACCESS, CAPTURE, DONE} state_t;

  state_t state, next_state;
  logic   sel, window, cpu_write, op_write;
  logic   load_op, post, drain, draining;

  assign sel       = ~z_mreq_n & (~z_rd_n | ~z_wr_n) &
                     (z_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
  assign window    = cmpblk & ~vram_busy;
  assign cpu_write = ~z_wr_n;
  // A write posted in this very cycle must not pull WAIT low even for one cycle.
  assign z_wait_n  = ~(rst_n & sel & (state != DONE) & ~post);

`ifdef VRAM_POSTED_WRITE_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
`endif

  always_comb begin
    next_state = state;
    load_op    = 1'b0;
    post       = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
`ifdef VRAM_POSTED_WRITE_EN
        if (buf_valid && window) begin
          next_state = ACCESS;
          drain      = 1'b1;
        end else if (sel && cpu_write && !buf_valid) begin
          next_state = DONE;
          post       = 1'b1;
        end else if (sel) begin
          next_state = WAITWIN;
        end
`else
        if (sel) next_state = WAITWIN;
`endif
      end
      WAITWIN: begin
`ifdef VRAM_POSTED_WRITE_EN
        // A pending posted write always drains before the waiting access, keeping order.
        if (buf_valid && window) begin
          next_state = ACCESS;
          drain      = 1'b1;
        end else if (!sel) begin
          next_state = IDLE;
        end else if (!buf_valid && window) begin
          next_state = ACCESS;
          load_op    = 1'b1;
        end
`else
        if (!sel) begin
          next_state = IDLE;
        end else if (window) begin
          next_state = ACCESS;
          load_op    = 1'b1;
        end
`endif
      end
      ACCESS: begin
        if (!sel || draining) next_state = IDLE;
        else if (op_write)    next_state = DONE;
        else                  next_state = CAPTURE;
      end
      CAPTURE: next_state = sel ? DONE : IDLE;
      DONE:    if (!sel) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      tile_ena <= 1'b0;
      addr     <= '0;
      din      <= '0;
      z_din    <= '0;
      op_write <= 1'b0;
    end else begin
      state    <= next_state;
      rdn      <= ~(load_op & ~cpu_write);
      wrn      <= ~((load_op & cpu_write) | drain);
      tile_ena <= load_op | drain;
      if (load_op) begin
        addr     <= z_addr[ADDR_W-1:0];
        din      <= z_dout;
        op_write <= cpu_write;
      end
`ifdef VRAM_POSTED_WRITE_EN
      if (drain) begin
        addr     <= buf_addr;
        din      <= buf_data;
        op_write <= 1'b1;
      end
`endif
      if (state == CAPTURE) z_din <= dout;
    end
  end

`ifdef VRAM_POSTED_WRITE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      draining  <= 1'b0;
    end else begin
      if (post) begin
        buf_valid <= 1'b1;
        buf_addr  <= z_addr[ADDR_W-1:0];
        buf_data  <= z_dout;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end
      draining <= drain;
    end
  end
`else
  assign draining = 1'b0;
`endif

endmodule

// File: tb/tb_vram_cpu_port.sv
// Randomized bench for vram_cpu_port: a transaction-level memory image and an ordered
// queue of expected tile RAM writes predict read data and every strobe on the tile port.
module tb_vram_cpu_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       z_mreq_n, z_rd_n, z_wr_n;
  logic [15:0] z_addr;
  logic [7:0] z_dout, z_din;
  logic       z_wait_n;
  logic       cmpblk, vram_busy;
  logic       rdn, wrn, tile_ena;
  logic [9:0] addr;
  logic [7:0] din, dout;

  logic [7:0]  ram     [1024];
  logic [7:0]  ref_mem [1024];
  logic [17:0] exp_wr  [$];
  bit          rd_exp_valid = 1'b0;
  logic [9:0]  rd_exp_addr  = '0;
  int          rd_cnt = 0, wr_cnt = 0;
  int          n_vec = 0, n_err = 0;
  bit          force_cmpblk = 1'b0, force_busy = 1'b0;
  int          force_cnt = 0;
  bit          win_edge = 1'b0;

  always #5 clk = ~clk;

  vram_cpu_port dut (
    .clk(clk), .rst_n(rst_n),
    .z_mreq_n(z_mreq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
    .z_addr(z_addr), .z_dout(z_dout), .z_din(z_din), .z_wait_n(z_wait_n),
    .cmpblk(cmpblk), .vram_busy(vram_busy),
    .rdn(rdn), .wrn(wrn), .tile_ena(tile_ena),
    .addr(addr), .din(din), .dout(dout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Synchronous tile RAM: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (tile_ena && !wrn) ram[addr] <= din;
    if (tile_ena && !rdn) dout <= ram[addr];
  end

  // Video timing: random unless a test pins the window for a number of cycles.
  initial begin
    cmpblk = 1'b0;
    vram_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (force_cnt > 0) begin
        cmpblk    = force_cmpblk;
        vram_busy = force_busy;
        force_cnt--;
      end else begin
        cmpblk    = ($urandom_range(0, 9) < 4);
        vram_busy = ($urandom_range(0, 9) < 3);
      end
    end
  end

  // Strobe monitor: every strobe must follow an open window and match the model.
  always begin
    logic [17:0] e;
    @(posedge clk);
    win_edge = cmpblk & ~vram_busy;
    #1;
    if (!rdn || !wrn) begin
      checkOutput("strobe_excl", rdn | wrn, 1);
      checkOutput("strobe_win", win_edge, 1);
      checkOutput("strobe_ena", tile_ena, 1);
    end
    if (!rdn) begin
      rd_cnt++;
      checkOutput("rd_expected", rd_exp_valid, 1);
      checkOutput("rd_addr", addr, rd_exp_addr);
      checkOutput("rd_order", exp_wr.size(), 0);
    end
    if (!wrn) begin
      wr_cnt++;
      checkOutput("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        checkOutput("wr_addr", addr, e[17:8]);
        checkOutput("wr_data", din, e[7:0]);
      end
    end
  end

  task automatic applyStimulus(input bit wr, input logic [15:0] a, input logic [7:0] d,
                               input bit fc, input bit fb, input int fn);
    bit         in_win, exp_nowait, waited;
    int         cyc, rd0, wr0;
    logic [7:0] exp_rd;
    in_win     = (a >= 16'h7400) && (a <= 16'h77FF);
    exp_nowait = !in_win;
`ifdef VRAM_POSTED_WRITE_EN
    if (wr && in_win && exp_wr.size() == 0) exp_nowait = 1'b1;
`endif
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    exp_rd = '0;
    if (in_win) begin
      if (wr) begin
        exp_wr.push_back({a[9:0], d});
        ref_mem[a[9:0]] = d;
      end else begin
        rd_exp_valid = 1'b1;
        rd_exp_addr  = a[9:0];
        exp_rd       = ref_mem[a[9:0]];
      end
    end
    force_cmpblk = fc;
    force_busy   = fb;
    force_cnt    = fn;
    @(negedge clk);
    z_addr = a;
    z_dout = d;
    z_mreq_n = 1'b0;
    z_rd_n = wr;
    z_wr_n = !wr;
    #1;
    waited = 1'b0;
    cyc = 0;
    while (!z_wait_n && cyc < 300) begin
      waited = 1'b1;
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput("wait_bound", cyc < 300, 1);
    checkOutput("wait_seen", waited, !exp_nowait);
    if (in_win && !wr) begin
      checkOutput("rd_data", z_din, exp_rd);
      checkOutput("rd_strobes", rd_cnt - rd0, 1);
    end else begin
      checkOutput("rd_strobes", rd_cnt - rd0, 0);
    end
`ifndef VRAM_POSTED_WRITE_EN
    checkOutput("wr_strobes", wr_cnt - wr0, (wr && in_win) ? 1 : 0);
`endif
    rd_exp_valid = 1'b0;
    @(negedge clk);
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    z_wr_n = 1'b1;
  endtask

  task automatic applyAbort(input logic [15:0] a);
    int rd0;
    rd0 = rd_cnt;
    force_cmpblk = 1'b0;
    force_busy   = 1'b0;
    force_cnt    = 8;
    @(negedge clk);
    z_addr = a;
    z_mreq_n = 1'b0;
    z_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkOutput("abort_wait", z_wait_n, 0);
    @(negedge clk);
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_strobe", rd_cnt - rd0, 0);
  endtask

  task automatic drainWait();
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_wr.size(), 0);
  endtask

  initial begin
    logic [15:0] a;
    int rd0;
    rst_n = 1'b0;
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    z_wr_n = 1'b1;
    z_addr = '0;
    z_dout = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset held with an in-window read and an open window on the bus.
    force_cmpblk = 1'b1;
    force_busy = 1'b0;
    force_cnt = 6;
    @(negedge clk);
    z_addr = 16'h7440;
    z_mreq_n = 1'b0;
    z_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rdn", rdn, 1);
    checkOutput("rst_wrn", wrn, 1);
    checkOutput("rst_tile_ena", tile_ena, 0);
    checkOutput("rst_wait_n", z_wait_n, 1);
    checkOutput("rst_z_din", z_din, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_din", din, 0);
    @(negedge clk);
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    ram[10'h040] = 8'hA5;
    ref_mem[10'h040] = 8'hA5;
    applyStimulus(1'b0, 16'h7440, 8'h00, 1'b0, 1'b0, 6);
    applyStimulus(1'b1, 16'h77BF, 8'h3C, 1'b1, 1'b1, 6);
    applyStimulus(1'b0, 16'h7800, 8'h00, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'h7800, 8'h77, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 16'h73FF, 8'h00, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'h73FF, 8'h5A, 1'b0, 1'b0, 0);
    applyAbort(16'h7500);
    drainWait();

    applyStimulus(1'b1, 16'h7400, 8'h11, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 16'h7400, 8'h00, 1'b0, 1'b0, 6);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) a = 16'h7400 | 16'($urandom_range(0, 1023));
      else                          a = 16'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0, 1'b0, 0);
    end
    drainWait();

    // Reset arriving while a read waits for its window must drop the access.
    rd0 = rd_cnt;
    force_cmpblk = 1'b0;
    force_busy = 1'b0;
    force_cnt = 6;
    @(negedge clk);
    z_addr = 16'h7500;
    z_mreq_n = 1'b0;
    z_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 checkOutput("midrst_wait_n", z_wait_n, 1);
    @(negedge clk);
    #1 checkOutput("midrst_rdn", rdn, 1);
    z_mreq_n = 1'b1;
    z_rd_n = 1'b1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("midrst_no_strobe", rd_cnt - rd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
